// File: rtl/i2c_target_regfile.sv
// I2C target serving a 2**PTR_W byte register file, with a local read/write port.
// scl/sda are oversampled on clk; the target drives sda low or releases it, and never stretches.
module i2c_target_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned PTR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic             loc_we,
  input  logic [7:0]       loc_wdata,
  output logic [7:0]       loc_rdata,
  output logic             bus_wr,
  output logic [PTR_W-1:0] bus_wr_addr,
  output logic             busy
);

  localparam int unsigned NumRegs = 2 ** PTR_W;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWrData, StWrAck, StRdData, StRdAck
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             scl_h_q, sda_h_q;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             rw_q, rw_d;
  logic             bus_wr_q, bus_wr_d;
  logic [PTR_W-1:0] bus_wr_addr_q, bus_wr_addr_d;
  logic             reg_we;
  logic [7:0]       regs_q [NumRegs];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_h_q;
  assign scl_fall  = ~scl_s & scl_h_q;
  assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  // State register: synchronisers idle high to match a released bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      scl_sync_q    <= 2'b11;
      sda_sync_q    <= 2'b11;
      scl_h_q       <= 1'b1;
      sda_h_q       <= 1'b1;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 4'd0;
      ptr_q         <= '0;
      sda_oe_q      <= 1'b0;
      rw_q          <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_wr_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      scl_sync_q    <= {scl_sync_q[0], scl};
      sda_sync_q    <= {sda_sync_q[0], sda};
      scl_h_q       <= scl_s;
      sda_h_q       <= sda_s;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      ptr_q         <= ptr_d;
      sda_oe_q      <= sda_oe_d;
      rw_q          <= rw_d;
      bus_wr_q      <= bus_wr_d;
      bus_wr_addr_q <= bus_wr_addr_d;
    end
  end

  // Bus write is issued last so it wins a same-cycle collision with the local port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= 8'h00;
    end else begin
      if (loc_we) regs_q[loc_addr] <= loc_wdata;
      if (reg_we) regs_q[ptr_q] <= rx_byte;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    ptr_d         = ptr_q;
    sda_oe_d      = sda_oe_q;
    rw_d          = rw_q;
    bus_wr_d      = 1'b0;
    bus_wr_addr_d = bus_wr_addr_q;
    reg_we        = 1'b0;
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWrData: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == StAddr) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = StAddrAck;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = StIdle;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = StPtrAck;
              end else begin
                reg_we        = 1'b1;
                bus_wr_d      = 1'b1;
                bus_wr_addr_d = ptr_q;
                ptr_d         = ptr_q + 1'b1;
                state_d       = StWrAck;
              end
            end
          end
        end
        // bit_cnt 0: waiting for the 8th-bit fall; 1: ACK is on the bus until the 9th fall.
        StAddrAck, StPtrAck, StWrAck: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              if (state_q == StAddrAck && rw_q) begin
                state_d  = StRdData;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StRdData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = StRdAck;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              ptr_d     = ptr_q + 1'b1;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s) state_d = StIdle;
            else bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = StRdData;
            bit_cnt_d = 4'd0;
            shift_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
          end
        end
        StIdle: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != StIdle) && (state_q != StAddr);
    loc_rdata   = regs_q[loc_addr];
    bus_wr      = bus_wr_q;
    bus_wr_addr = bus_wr_addr_q;
  end

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C master driving i2c_target_regfile; expected responses are queued at issue
// time and a negedge monitor pairs them with observed bus/port responses.
module tb_i2c_target_regfile;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset, m_scl, m_sda_oe, loc_we;
  logic [3:0] loc_addr, bus_wr_addr;
  logic [7:0] loc_wdata, loc_rdata, rd;
  logic       bus_wr, busy, b;
  wire        sda;

  always #5 clk = ~clk;

  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup pu_sda (sda);

  i2c_target_regfile #(.SLAVE_ADDR(7'h42), .PTR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (m_scl),
    .sda        (sda),
    .loc_addr   (loc_addr),
    .loc_we     (loc_we),
    .loc_wdata  (loc_wdata),
    .loc_rdata  (loc_rdata),
    .bus_wr     (bus_wr),
    .bus_wr_addr(bus_wr_addr),
    .busy       (busy)
  );

  typedef struct {
    string name;
    int    val;
  } item_t;

  item_t exp_q[$];
  item_t act_q[$];
  int    wr_exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  bit    done = 1'b0;
  bit    done_seen = 1'b0;

  // Monitor: bus_wr pulses against queued addresses, observed responses against expectations.
  always @(negedge clk) begin
    item_t a, e;
    int    ea;
    if (bus_wr === 1'b1) begin
      n_tests++;
      if (wr_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_wr: unexpected write pulse, addr %0d", bus_wr_addr);
      end else begin
        ea = wr_exp_q.pop_front();
        if (bus_wr_addr !== 4'(ea)) begin
          n_fail++;
          $display("FAIL bus_wr_addr: got %0d, expected %0d", bus_wr_addr, ea);
        end
      end
    end
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: got %0d with no expectation queued", a.name, a.val);
      end else begin
        e = exp_q.pop_front();
        if (a.name != e.name || a.val != e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (%s)", a.name, a.val, e.val, e.name);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      n_tests++;
      if (exp_q.size() != 0 || wr_exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d responses and %0d writes never seen, expected 0 and 0",
                 exp_q.size(), wr_exp_q.size());
      end
    end
  end

  task automatic expect_val(input string n, input int v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string n, input int v);
    item_t it;
    it.name = n;
    it.val  = v;
    act_q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quarter();
    repeat (Q) tick();
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; quarter();
    m_scl    = 1'b1; quarter();
    m_sda_oe = 1'b1; quarter();
    m_scl    = 1'b0; quarter();
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; quarter();
    m_scl    = 1'b1; quarter();
    m_sda_oe = 1'b0; quarter();
  endtask

  task automatic read_bit(output logic v);
    m_sda_oe = 1'b0; quarter();
    m_scl    = 1'b1; quarter();
    v        = sda;  quarter();
    m_scl    = 1'b0; quarter();
  endtask

  // collide: pulse loc_we in the exact cycle the 8th-bit rise reaches the regfile
  // (2 synchroniser stages + 1 history stage after scl rises).
  task automatic write_byte(input logic [7:0] d, input bit collide, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda_oe = ~d[i]; quarter();
      m_scl    = 1'b1;
      if (collide && i == 0) begin
        tick(); tick();
        loc_we = 1'b1; tick();
        loc_we = 1'b0;
        repeat (2 * Q - 3) tick();
      end else begin
        quarter(); quarter();
      end
      m_scl = 1'b0; quarter();
    end
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
    m_sda_oe = ~nack; quarter();
    m_scl    = 1'b1;  quarter(); quarter();
    m_scl    = 1'b0;  quarter();
    m_sda_oe = 1'b0;
  endtask

  task automatic wr(input string n, input logic [7:0] d, input int exp_ack);
    logic ack;
    expect_val(n, exp_ack);
    write_byte(d, 1'b0, ack);
    observe(n, int'(ack));
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1; tick();
    loc_we = 1'b0;
  endtask

  task automatic loc_check(input string n, input logic [3:0] a, input int v);
    expect_val(n, v);
    loc_addr = a; #1;
    observe(n, int'(loc_rdata));
  endtask

  task automatic ptr_check(input string n, input int v);
    expect_val(n, v);
    observe(n, int'(dut.ptr_q));
  endtask

  task automatic busy_check(input string n, input int v);
    expect_val(n, v);
    observe(n, int'(busy));
  endtask

  initial begin
    reset = 1'b0; m_scl = 1'b1; m_sda_oe = 1'b0;
    loc_we = 1'b0; loc_addr = 4'd0; loc_wdata = 8'h00;
    repeat (4) tick();
    reset = 1'b1;
    repeat (4) tick();

    busy_check("rst_busy", 0);
    expect_val("rst_sda", 1); observe("rst_sda", int'(sda));
    ptr_check("rst_ptr", 0);
    loc_check("rst_reg7", 4'd7, 8'h00);

    // 1: single byte write to reg 3
    i2c_start();
    wr("t1_ack_addr", 8'h84, 0);
    busy_check("t1_busy", 1);
    wr("t1_ack_ptr", 8'h03, 0);
    wr_exp_q.push_back(3);
    wr("t1_ack_data", 8'hA5, 0);
    i2c_stop();
    loc_check("t1_reg3", 4'd3, 8'hA5);
    ptr_check("t1_ptr", 4);
    busy_check("t1_busy_idle", 0);

    // 2: wrong address is ignored, following byte must not write
    i2c_start();
    wr("t2_nack_addr", 8'h86, 1);
    busy_check("t2_busy", 0);
    wr("t2_ignored", 8'h55, 1);
    i2c_stop();
    loc_check("t2_reg3", 4'd3, 8'hA5);
    ptr_check("t2_ptr", 4);

    // 3: pointer wraps from F to 0
    i2c_start();
    wr("t3_ack_addr", 8'h84, 0);
    wr("t3_ack_ptr", 8'h0F, 0);
    wr_exp_q.push_back(15);
    wr("t3_ack_d0", 8'h11, 0);
    wr_exp_q.push_back(0);
    wr("t3_ack_d1", 8'h22, 0);
    i2c_stop();
    loc_check("t3_regF", 4'd15, 8'h11);
    loc_check("t3_reg0", 4'd0, 8'h22);
    ptr_check("t3_ptr", 1);

    // 4: set pointer, repeated START, read two bytes
    loc_write(4'd2, 8'h5A);
    loc_write(4'd3, 8'hC3);
    i2c_start();
    wr("t4_ack_addr", 8'h84, 0);
    wr("t4_ack_ptr", 8'hF2, 0);
    i2c_start();
    wr("t4_ack_raddr", 8'h85, 0);
    expect_val("t4_rd0", 8'h5A);
    read_byte(1'b0, rd);
    observe("t4_rd0", int'(rd));
    expect_val("t4_rd1", 8'hC3);
    read_byte(1'b1, rd);
    observe("t4_rd1", int'(rd));
    expect_val("t4_sda_rel", 1); observe("t4_sda_rel", int'(sda));
    busy_check("t4_busy_nack", 0);
    i2c_stop();
    ptr_check("t4_ptr", 4);

    // 5: reset while the target drives a 0 data bit
    i2c_start();
    wr("t5_ack_addr", 8'h85, 0);
    m_sda_oe = 1'b0; tick();
    expect_val("t5_drive", 0); observe("t5_drive", int'(sda));
    reset = 1'b0; tick();
    reset = 1'b1;
    expect_val("t5_sda_rel", 1); observe("t5_sda_rel", int'(sda));
    busy_check("t5_busy", 0);
    loc_check("t5_reg3", 4'd3, 8'h00);
    loc_check("t5_regF", 4'd15, 8'h00);
    ptr_check("t5_ptr", 0);
    quarter();
    i2c_stop();

    // 6: bus and local write hit reg 5 in the same cycle
    i2c_start();
    wr("t6_ack_addr", 8'h84, 0);
    wr("t6_ack_ptr", 8'h05, 0);
    loc_addr = 4'd5; loc_wdata = 8'h77;
    wr_exp_q.push_back(5);
    expect_val("t6_ack_data", 0);
    write_byte(8'h99, 1'b1, b);
    observe("t6_ack_data", int'(b));
    i2c_stop();
    loc_check("t6_reg5", 4'd5, 8'h99);
    ptr_check("t6_ptr", 6);

    done = 1'b1;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
